// File: rtl/bf_loop_ctrl.sv
// Brainfuck loop-control stage: gates execution, resolves '[' / ']' against the bracket stack.
// Optional LOOP_CTRL_STATS_EN adds a saturating taken-back-jump counter (loop_iter_count).
module bf_loop_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              instr_valid,
    input  logic [2:0]        instr_in,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              cell_zero_in,
    output logic              instr_ready,
    output logic              exec_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              stk_push,
    output logic              stk_pop,
    output logic [ADDR_W-1:0] stk_data,
    input  logic [ADDR_W-1:0] stk_top,
    input  logic              stk_empty,
    input  logic              stk_full,
    output logic              err_unbalanced
`ifdef LOOP_CTRL_STATS_EN
    ,
    output logic [15:0]       loop_iter_count
`endif
);

    localparam logic [2:0]  OP_OPEN  = 3'd6;
    localparam logic [2:0]  OP_CLOSE = 3'd7;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ISSUE,
        ST_SKIP,
        ST_ERR
    } state_t;

    state_t              state_q;
    logic [DEPTH_W-1:0]  depth_q;
    logic                ready_q;
    logic                exec_q;
    logic                pc_load_q;
    logic                push_q;
    logic                pop_q;
    logic                err_q;
    logic [ADDR_W-1:0]   pc_target_q;
    logic [ADDR_W-1:0]   stk_data_q;
    logic [ADDR_W-1:0]   pc_target_d;
    logic                accept_c;

    // Back-jump lands just past the matching '['.
    assign pc_target_d = stk_top + ADDR_W'(1);
    assign accept_c    = instr_valid && ready_q;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_RUN;
            depth_q     <= '0;
            ready_q     <= 1'b1;
            exec_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            err_q       <= 1'b0;
            pc_target_q <= '0;
            stk_data_q  <= '0;
        end else begin
            exec_q    <= 1'b0;
            pc_load_q <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (accept_c) begin
                        case (instr_in)
                            OP_OPEN: begin
                                if (cell_zero_in) begin
                                    depth_q <= DEPTH_W'(1);
                                    state_q <= ST_SKIP;
                                end else if (stk_full) begin
                                    state_q <= ST_ERR;
                                    ready_q <= 1'b0;
                                    err_q   <= 1'b1;
                                end else begin
                                    push_q     <= 1'b1;
                                    stk_data_q <= pc_in;
                                    state_q    <= ST_ISSUE;
                                    ready_q    <= 1'b0;
                                end
                            end
                            OP_CLOSE: begin
                                if (stk_empty) begin
                                    state_q <= ST_ERR;
                                    ready_q <= 1'b0;
                                    err_q   <= 1'b1;
                                end else begin
                                    if (cell_zero_in) begin
                                        pop_q <= 1'b1;
                                    end else begin
                                        pc_load_q   <= 1'b1;
                                        pc_target_q <= pc_target_d;
                                    end
                                    state_q <= ST_ISSUE;
                                    ready_q <= 1'b0;
                                end
                            end
                            default: exec_q <= 1'b1;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_RUN;
                    ready_q <= 1'b1;
                end
                ST_SKIP: begin
                    // Forward scan: only bracket nesting matters, nothing executes.
                    if (accept_c) begin
                        if (instr_in == OP_OPEN) begin
                            if (depth_q == '1) begin
                                state_q <= ST_ERR;
                                ready_q <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                depth_q <= depth_q + DEPTH_W'(1);
                            end
                        end else if (instr_in == OP_CLOSE) begin
                            depth_q <= depth_q - DEPTH_W'(1);
                            if (depth_q == DEPTH_W'(1)) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_ERR;
                    ready_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready    = ready_q;
    assign exec_en        = exec_q;
    assign pc_load        = pc_load_q;
    assign pc_target      = pc_target_q;
    assign stk_push       = push_q;
    assign stk_pop        = pop_q;
    assign stk_data       = stk_data_q;
    assign err_unbalanced = err_q;

`ifdef LOOP_CTRL_STATS_EN
    logic [CNT_W-1:0] iter_q;

    // Counts taken back-jumps, saturating.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            iter_q <= '0;
        end else if (pc_load_q && (iter_q != '1)) begin
            iter_q <= iter_q + CNT_W'(1);
        end
    end

    assign loop_iter_count = iter_q;
`endif

endmodule
